score_keeper: RTL and testbench

- Parametrised successor to the rhythm-game scoreboard.
- Accumulates note-hit points with a combo multiplier, saturates at a configurable ceiling, and converts the score to BCD. The conversion is a multi-cycle sequential double-dabble engine, not combinational.
- Drives DIGITS active-low seven-segment displays.
- Sits between the note-judgement logic (hit/miss/islong pulses) and the board HEX outputs.

---
 rtl/score_keeper.sv | 215 +++++++++++++++++++++
 tb/tb_score_keeper.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: combo-multiplied, saturating rhythm-game score with a sequential double-dabble
// BCD converter feeding active-low 7-segment digits. Define SCORE_KEEPER_HIGH_SCORE_EN for high score.
module score_keeper #(
    parameter int unsigned SCORE_W    = 14,
    parameter int unsigned DIGITS     = 4,
    parameter int unsigned MAX_SCORE  = 9999,
    parameter int unsigned SHORT_PTS  = 1,
    parameter int unsigned LONG_PTS   = 3,
    parameter int unsigned COMBO_STEP = 8,
    parameter int unsigned MAX_MULT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  hit,
    input  logic                  islong,
    input  logic                  miss,
    input  logic                  show_high,
    output logic [SCORE_W-1:0]    score,
    output logic [2:0]            mult,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic [7*DIGITS-1:0]   segments,
    output logic [SCORE_W-1:0]    high_score
);

    localparam int unsigned SUM_W  = SCORE_W + 4;
    localparam int unsigned STRK_W = $clog2(COMBO_STEP + 1);
    localparam int unsigned CNT_W  = $clog2(SCORE_W + 1);
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam logic [6:0]  SEG_ZERO = 7'b1000000;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

    logic [SCORE_W-1:0]  r_score, w_score_d;
    logic [STRK_W-1:0]   r_streak, w_streak_d;
    logic [2:0]          r_mult, w_mult_d;
    logic [SUM_W-1:0]    w_pts, w_sum;
    logic [SCORE_W-1:0]  w_src_d;
    logic                w_chg;

    state_e              r_state, w_state_d;
    logic [SCORE_W-1:0]  r_snap, w_snap_d;
    logic [BCD_W-1:0]    r_work, w_work_d, w_adj;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic                r_pending, w_pending_d;
    logic [BCD_W-1:0]    r_bcd, w_bcd_d;
    logic                r_valid, w_valid_d;
    logic [7*DIGITS-1:0] r_seg, w_seg_d, w_seg_dec;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Points use the multiplier before this cycle's combo update; the sum is wide so it never wraps.
    always_comb begin
        w_pts      = islong ? SUM_W'(LONG_PTS) : SUM_W'(SHORT_PTS);
        w_sum      = {4'b0000, r_score} + w_pts * SUM_W'(r_mult);
        w_score_d  = r_score;
        w_streak_d = r_streak;
        w_mult_d   = r_mult;
        if (clear) begin
            w_score_d  = '0;
            w_streak_d = '0;
            w_mult_d   = 3'd1;
        end else begin
            if (hit) begin
                w_score_d = (w_sum > SUM_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                        : w_sum[SCORE_W-1:0];
            end
            if (miss) begin
                w_streak_d = '0;
                w_mult_d   = 3'd1;
            end else if (hit) begin
                if (r_streak == STRK_W'(COMBO_STEP - 1)) begin
                    w_streak_d = '0;
                    if (r_mult < 3'(MAX_MULT)) w_mult_d = r_mult + 3'd1;
                end else begin
                    w_streak_d = r_streak + STRK_W'(1);
                end
            end
        end
    end

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
    logic [SCORE_W-1:0] r_high, w_high_d;
    logic               r_show;

    always_comb begin
        w_high_d = (r_score > r_high) ? r_score : r_high;
        w_src_d  = show_high ? w_high_d : w_score_d;
        w_chg    = (w_score_d != r_score) || (show_high != r_show) ||
                   (show_high && (w_high_d != r_high));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_high <= '0;
            r_show <= 1'b0;
        end else begin
            r_high <= w_high_d;
            r_show <= show_high;
        end
    end

    assign high_score = r_high;
`else
    logic w_unused_show;
    assign w_unused_show = show_high;
    assign w_src_d       = w_score_d;
    assign w_chg         = (w_score_d != r_score);
    assign high_score    = '0;
`endif

    always_comb begin
        w_adj = r_work;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_work[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_work[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_seg_dec = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_seg_dec[7*k +: 7] = seg7(r_work[4*k +: 4]);
        end
    end

    // A change seen in IDLE starts a conversion at once (snapshot of the next value);
    // any other change is remembered in pending and keeps bcd_valid low through COMMIT.
    always_comb begin
        w_state_d   = r_state;
        w_snap_d    = r_snap;
        w_work_d    = r_work;
        w_cnt_d     = r_cnt;
        w_pending_d = r_pending | w_chg;
        w_bcd_d     = r_bcd;
        w_seg_d     = r_seg;
        w_valid_d   = r_valid & ~w_chg;
        unique case (r_state)
            StIdle: begin
                if (r_pending || w_chg) begin
                    w_state_d   = StLoad;
                    w_snap_d    = w_src_d;
                    w_work_d    = '0;
                    w_pending_d = 1'b0;
                end
            end
            StLoad: begin
                w_state_d = StShift;
                w_cnt_d   = '0;
            end
            StShift: begin
                w_work_d = {w_adj[BCD_W-2:0], r_snap[SCORE_W-1]};
                w_snap_d = {r_snap[SCORE_W-2:0], 1'b0};
                w_cnt_d  = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(SCORE_W - 1)) w_state_d = StCommit;
            end
            StCommit: begin
                w_bcd_d   = r_work;
                w_seg_d   = w_seg_dec;
                w_valid_d = ~(r_pending | w_chg);
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score   <= '0;
            r_streak  <= '0;
            r_mult    <= 3'd1;
            r_state   <= StIdle;
            r_snap    <= '0;
            r_work    <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_bcd     <= '0;
            r_valid   <= 1'b1;
            r_seg     <= {DIGITS{SEG_ZERO}};
        end else begin
            r_score   <= w_score_d;
            r_streak  <= w_streak_d;
            r_mult    <= w_mult_d;
            r_state   <= w_state_d;
            r_snap    <= w_snap_d;
            r_work    <= w_work_d;
            r_cnt     <= w_cnt_d;
            r_pending <= w_pending_d;
            r_bcd     <= w_bcd_d;
            r_valid   <= w_valid_d;
            r_seg     <= w_seg_d;
        end
    end

    assign score     = r_score;
    assign mult      = r_mult;
    assign bcd       = r_bcd;
    assign bcd_valid = r_valid;
    assign segments  = r_seg;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: vector table, directed corner sequences and
// randomized traffic against an arithmetic model of score, combo and displayed value.
module tb_score_keeper;

    localparam int SCORE_W    = 14;
    localparam int DIGITS     = 4;
    localparam int MAX_SCORE  = 9999;
    localparam int SHORT_PTS  = 1;
    localparam int LONG_PTS   = 3;
    localparam int COMBO_STEP = 8;
    localparam int MAX_MULT   = 4;

    logic                  clk = 1'b0;
    logic                  reset, clear, hit, islong, miss, show_high;
    logic [SCORE_W-1:0]    score, high_score;
    logic [2:0]            mult;
    logic [4*DIGITS-1:0]   bcd;
    logic                  bcd_valid;
    logic [7*DIGITS-1:0]   segments;

    score_keeper #(
        .SCORE_W(SCORE_W), .DIGITS(DIGITS), .MAX_SCORE(MAX_SCORE), .SHORT_PTS(SHORT_PTS),
        .LONG_PTS(LONG_PTS), .COMBO_STEP(COMBO_STEP), .MAX_MULT(MAX_MULT)
    ) dut (
        .clk(clk), .reset(reset), .clear(clear), .hit(hit), .islong(islong), .miss(miss),
        .show_high(show_high), .score(score), .mult(mult), .bcd(bcd), .bcd_valid(bcd_valid),
        .segments(segments), .high_score(high_score)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_score, m_streak, m_mult;
    int hist[$];

    typedef struct {
        logic c; logic h; logic l; logic m;
        int exp_score; int exp_mult;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        int d = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] exp_seg(input int v);
        logic [7*DIGITS-1:0] s = '0;
        int d = v;
        for (int i = 0; i < DIGITS; i++) begin
            s[7*i +: 7] = seg_of(d % 10);
            d = d / 10;
        end
        return s;
    endfunction

    function automatic bit in_hist(input logic [4*DIGITS-1:0] b);
        foreach (hist[i]) if (to_bcd(hist[i]) == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input logic c, input logic h, input logic l, input logic m);
        if (c) begin
            m_score = 0; m_streak = 0; m_mult = 1;
        end else begin
            if (h) begin
                m_score = m_score + (l ? LONG_PTS : SHORT_PTS) * m_mult;
                if (m_score > MAX_SCORE) m_score = MAX_SCORE;
            end
            if (m) begin
                m_streak = 0; m_mult = 1;
            end else if (h) begin
                m_streak++;
                if (m_streak == COMBO_STEP) begin
                    m_streak = 0;
                    if (m_mult < MAX_MULT) m_mult++;
                end
            end
        end
    endtask

    // One clock: drive pulses, advance the model at the edge, sample 1 time unit later.
    task automatic cyc(input logic c, input logic h, input logic l, input logic m);
        clear = c; hit = h; islong = l; miss = m;
        @(posedge clk);
        model_step(c, h, l, m);
        #1;
        clear = 1'b0; hit = 1'b0; islong = 1'b0; miss = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = -1;
        for (int k = 1; k <= limit && n < 0; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            if (bcd_valid) n = k;
        end
        if (n < 0) check("bcd_valid_timeout", 0, 1);
    endtask

    // Greedy walk to an exact score; a bare miss drops the multiplier when the step is too big.
    task automatic reach(input int target);
        while (m_score < target) begin
            if (target - m_score >= LONG_PTS * m_mult) cyc(1'b0, 1'b1, 1'b1, 1'b0);
            else if (target - m_score >= SHORT_PTS * m_mult) cyc(1'b0, 1'b1, 1'b0, 1'b0);
            else cyc(1'b0, 1'b0, 1'b0, 1'b1);
        end
        check("reach_score", score, target);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_score"}, score, 0);
        check({tag, "_mult"}, mult, 1);
        check({tag, "_bcd"}, bcd, 0);
        check({tag, "_valid"}, bcd_valid, 1);
        check({tag, "_segments"}, segments, {DIGITS{7'b1000000}});
        check({tag, "_high"}, high_score, 0);
    endtask

    initial begin
        logic rc, rh, rl, rm;
        int   lat;

        reset = 1'b1; clear = 1'b0; hit = 1'b0; islong = 1'b0; miss = 1'b0; show_high = 1'b0;
        m_score = 0; m_streak = 0; m_mult = 1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Three spaced short hits, each displayed exactly SCORE_W+2 cycles later.
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            check("valid_drop", bcd_valid, 0);
            wait_valid(40, lat);
            check("latency", lat, SCORE_W + 2);
            check("bcd_after_hit", bcd, to_bcd(i));
            if (lat > 0 && lat < 19) repeat (19 - lat) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
        check("three_hits_score", score, 3);
        check("three_hits_mult", mult, 1);
        check("three_hits_bcd", bcd, 16'h0003);
        check("three_hits_seg0", segments[6:0], 7'b0110000);
        check("three_hits_segments", segments, exp_seg(3));

        // Vector table: {clear, hit, islong, miss} -> score, mult after the edge.
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 0, 1});
        for (int i = 1; i <= 8; i++) vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, i, (i == 8) ? 2 : 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 10, 2});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 16, 2});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 16, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 19, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 19, 1});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 2, 1});
        foreach (vecs[i]) begin
            cyc(vecs[i].c, vecs[i].h, vecs[i].l, vecs[i].m);
            check($sformatf("vec%0d_score", i), score, vecs[i].exp_score);
            check($sformatf("vec%0d_mult", i), mult, vecs[i].exp_mult);
        end
        wait_valid(60, lat);
        check("table_bcd", bcd, 16'h0002);

        // Multiplier cap, then hit+islong+miss together.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (24) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("cap_mult", mult, 4);
        check("cap_score", score, 48);
        repeat (24) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("cap_hold_mult", mult, 4);
        check("cap_hold_score", score, 144);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("hit_miss_score", score, 156);
        check("hit_miss_mult", mult, 1);
        repeat (7) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("streak_restart_mult", mult, 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("streak_restart_step", mult, 2);
        check("streak_restart_score", score, 164);

        // Randomized traffic against the model.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            rc = ($urandom_range(0, 99) < 2);
            rh = ($urandom_range(0, 99) < 60);
            rl = 1'($urandom_range(0, 1));
            rm = ($urandom_range(0, 99) < 8);
            cyc(rc, rh, rl, rm);
            check("rnd_score", score, m_score);
            check("rnd_mult", mult, m_mult);
        end
        wait_valid(60, lat);
        check("rnd_bcd", bcd, to_bcd(m_score));
        check("rnd_segments", segments, exp_seg(m_score));

        // Saturation at the ceiling.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        reach(9947);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (24) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_sat_score", score, 9995);
        check("pre_sat_mult", mult, 4);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("sat_score", score, 9999);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check("sat_hold_score", score, 9999);
        wait_valid(60, lat);
        check("sat_bcd", bcd, 16'h9999);
        check("sat_segments", segments, exp_seg(9999));

        // Burst of hits during conversion: never valid, never a partial value.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        wait_valid(60, lat);
        hist.delete();
        hist.push_back(m_score);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            hist.push_back(m_score);
            check("burst_valid", bcd_valid, 0);
            check("burst_partial", in_hist(bcd), 1);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check("burst_valid", bcd_valid, 0);
            check("burst_partial", in_hist(bcd), 1);
        end
        wait_valid(60, lat);
        check("burst_final_bcd", bcd, to_bcd(m_score));

        // Asynchronous reset in the middle of SHIFT.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_shift_valid", bcd_valid, 0);
        #3 reset = 1'b1;
        #1;
        check_reset_state("mid_reset");
        m_score = 0; m_streak = 0; m_mult = 1;
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        repeat (20) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("post_reset_bcd", bcd, 0);
        check("post_reset_valid", bcd_valid, 1);

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
        reach(50);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        reach(20);
        wait_valid(60, lat);
        check("hs_score_bcd", bcd, 16'h0020);
        show_high = 1'b1;
        wait_valid(60, lat);
        check("hs_high", high_score, 50);
        check("hs_bcd", bcd, 16'h0050);
        show_high = 1'b0;
        wait_valid(60, lat);
        check("hs_back_bcd", bcd, 16'h0020);
`else
        reach(37);
        wait_valid(60, lat);
        show_high = 1'b1;
        repeat (20) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("no_hs_valid", bcd_valid, 1);
        check("no_hs_bcd", bcd, 16'h0037);
        check("no_hs_high", high_score, 0);
        show_high = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
